// File: rtl/cache_pkg.sv
// Shared cache fill definitions: geometry, fill state encoding and block address helpers.
// Also used by the D-cache fill engine.
package cache_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned BLK_WORDS   = 8;
    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned OFFSET_W    = 4;
    localparam int unsigned WORD_IDX_W  = 3;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned BLK_ADDR_W  = ADDR_W - OFFSET_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Byte address of word word_idx within block blk; bits [3:0] never carry upward.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [BLK_ADDR_W-1:0] blk,
        input logic [WORD_IDX_W-1:0] word_idx
    );
        return {blk, word_idx, 1'b0};
    endfunction

endpackage

// File: rtl/fill_word_cnt.sv
// Word counter for block fills: sync reset/clear, count enable, terminal-count flag.
module fill_word_cnt
    import cache_pkg::*;
#(
    parameter int unsigned TERM = BLK_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term_c
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term_c = (cnt == CNT_W'(TERM));

endmodule

// File: rtl/icache_fill_fsm.sv
// I-cache miss fill engine: issues 8 pipelined word reads per block, streams returns
// into the data array, then writes the tag. Stalls fetch while the block is absent.
module icache_fill_fsm
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_W-1:0]     miss_address,
    input  logic [DATA_W-1:0]     memory_data,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  mem_enable,
    output logic [ADDR_W-1:0]     memory_address,
    output logic                  write_data_array,
    output logic [WORD_IDX_W-1:0] fill_offset,
    output logic [DATA_W-1:0]     fill_data,
    output logic                  write_tag_array
);

    fill_state_t           state;
    logic [BLK_ADDR_W-1:0] base_blk;
    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      recv_cnt;
    logic                  issue_done;
    logic                  recv_last;
    logic                  in_fill;
    logic                  start_fill;
    logic                  unused_offset_bits;

    assign in_fill    = (state == FILL);
    assign start_fill = (state == IDLE) && miss_detected;

    // Only the block number is kept; the in-block offset of the miss is irrelevant.
    assign unused_offset_bits = ^miss_address[OFFSET_W-1:0];

    fill_word_cnt #(.TERM(BLK_WORDS)) u_issue_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_fill),
        .en     (mem_enable),
        .cnt    (issue_cnt),
        .term_c (issue_done)
    );

    fill_word_cnt #(.TERM(BLK_WORDS - 1)) u_recv_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_fill),
        .en     (write_data_array),
        .cnt    (recv_cnt),
        .term_c (recv_last)
    );

    // State and block base; misses seen during FILL are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_blk <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        state    <= FILL;
                        base_blk <= miss_address[ADDR_W-1:OFFSET_W];
                    end
                end
                FILL: begin
                    if (write_tag_array) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The miss cycle itself already stalls fetch.
    assign fsm_busy         = in_fill || miss_detected;
    assign mem_enable       = in_fill && !issue_done;
    assign memory_address   = in_fill ? word_addr(base_blk, issue_cnt[WORD_IDX_W-1:0]) : '0;
    assign write_data_array = in_fill && memory_data_valid;
    assign fill_offset      = write_data_array ? recv_cnt[WORD_IDX_W-1:0] : '0;
    assign fill_data        = write_data_array ? memory_data : '0;
    assign write_tag_array  = write_data_array && recv_last;

endmodule

// File: tb/tb_icache_fill_fsm.sv
// Self-checking bench for icache_fill_fsm with a 4-cycle pipelined memory model.
module tb_icache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_enable;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_offset;
    logic [15:0] fill_data;
    logic        write_tag_array;

    int pass_cnt  = 0;
    int check_cnt = 0;

    bit [3:0]    pv;
    logic [15:0] pa [4];
    bit          force_valid = 1'b0;
    logic [15:0] force_data  = 16'h0;

    always #5 clk = ~clk;

    icache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_enable        (mem_enable),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_offset       (fill_offset),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    // Memory: request seen at an edge returns after four edges, data = addr ^ A5A5.
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_enable};
        pa[0] <= memory_address;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end

    assign memory_data_valid = pv[3] | force_valid;
    assign memory_data       = pv[3] ? (pa[3] ^ 16'hA5A5) : force_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drives a miss on the current negedge and tracks the whole fill to its tag write.
    task automatic run_fill(input logic [15:0] addr, input bit hold,
                            input logic [15:0] base, input string tag);
        int nreq = 0, nwr = 0, first_req = -1, last_req = -1;
        int addr_err = 0, data_err = 0, busy_err = 0, tag_err = 0;
        bit done = 1'b0;
        miss_detected = 1'b1;
        miss_address  = addr;
        #1;
        check({tag, "_busy_on_miss"}, 32'(fsm_busy), 32'd1);
        check({tag, "_no_req_in_idle"}, 32'(mem_enable), 32'd0);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (!hold) miss_detected = 1'b0;
            if (!fsm_busy) busy_err++;
            if (mem_enable) begin
                if (memory_address !== 16'(base + 16'(2 * nreq))) addr_err++;
                if (first_req < 0) first_req = cyc;
                last_req = cyc;
                nreq++;
            end
            if (write_data_array) begin
                if (fill_offset !== 3'(nwr)) data_err++;
                if (fill_data !== (16'(base + 16'(2 * nwr)) ^ 16'hA5A5)) data_err++;
                nwr++;
                if (write_tag_array) begin
                    done = 1'b1;
                    if (nwr != 8) tag_err++;
                end
            end else if (write_tag_array) begin
                tag_err++;
            end
        end
        check({tag, "_completed"}, 32'(done), 32'd1);
        check({tag, "_req_count"}, 32'(nreq), 32'd8);
        check({tag, "_req_start"}, 32'(first_req), 32'd0);
        check({tag, "_req_consecutive"}, 32'(last_req - first_req), 32'd7);
        check({tag, "_req_addr_errs"}, 32'(addr_err), 32'd0);
        check({tag, "_write_count"}, 32'(nwr), 32'd8);
        check({tag, "_write_errs"}, 32'(data_err), 32'd0);
        check({tag, "_tag_errs"}, 32'(tag_err), 32'd0);
        check({tag, "_busy_errs"}, 32'(busy_err), 32'd0);
        if (!hold) begin
            @(negedge clk);
            check({tag, "_busy_drops"}, 32'(fsm_busy), 32'd0);
            check({tag, "_idle_no_req"}, 32'(mem_enable), 32'd0);
        end
    endtask

    typedef struct {
        logic [15:0] miss_addr;
        logic [15:0] exp_base;
        string       name;
    } fill_vec_t;

    initial begin
        fill_vec_t vecs [4];
        int wr_seen, tag_seen, nwr;

        vecs[0] = '{16'h1236, 16'h1230, "fill_1236"};
        vecs[1] = '{16'hFFFE, 16'hFFF0, "fill_fffe"};
        vecs[2] = '{16'h0001, 16'h0000, "fill_0001"};
        vecs[3] = '{16'hABCF, 16'hABC0, "fill_abcf"};

        rst           = 1'b1;
        miss_detected = 1'b0;
        miss_address  = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(fsm_busy), 32'd0);
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_mem_addr", 32'(memory_address), 32'd0);
        check("rst_wr_data", 32'(write_data_array), 32'd0);
        check("rst_offset", 32'(fill_offset), 32'd0);
        check("rst_fill_data", 32'(fill_data), 32'd0);
        check("rst_wr_tag", 32'(write_tag_array), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table of ordinary fills, including the top-of-memory block
        foreach (vecs[i]) begin
            run_fill(vecs[i].miss_addr, 1'b0, vecs[i].exp_base, vecs[i].name);
            @(negedge clk);
        end

        // Miss held through the fill, then a back-to-back fill
        run_fill(16'h1236, 1'b1, 16'h1230, "hold");
        @(negedge clk);
        run_fill(16'h1236, 1'b0, 16'h1230, "refill");
        @(negedge clk);

        // Reset after three data writes
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        nwr = 0;
        for (int cyc = 0; cyc < 40 && nwr < 3; cyc++) begin
            @(negedge clk);
            miss_detected = 1'b0;
            if (write_data_array) nwr++;
        end
        check("abort_reached_3_writes", 32'(nwr), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(fsm_busy), 32'd0);
        check("abort_mem_enable", 32'(mem_enable), 32'd0);
        rst = 1'b0;
        wr_seen  = 0;
        tag_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (write_data_array) wr_seen++;
            if (write_tag_array) tag_seen++;
        end
        check("abort_no_stale_writes", 32'(wr_seen), 32'd0);
        check("abort_no_tag", 32'(tag_seen), 32'd0);
        run_fill(16'h2000, 1'b0, 16'h2000, "after_abort");
        @(negedge clk);

        // Stray valid in IDLE
        force_valid = 1'b1;
        force_data  = 16'h1234;
        #1;
        check("idle_valid_no_wr", 32'(write_data_array), 32'd0);
        check("idle_valid_no_tag", 32'(write_tag_array), 32'd0);
        check("idle_valid_busy", 32'(fsm_busy), 32'd0);
        check("idle_valid_fill_data", 32'(fill_data), 32'd0);
        @(negedge clk);
        force_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
